aes_round_sched: RTL and testbench

Iterative AES-128 encryption sequencer that time-multiplexes a single encryption-round datapath over all rounds of one block. It accepts a plaintext block through a valid/ready handshake and performs the initial AddRoundKey internally. It then drives the round datapath NR times, fetching one round key per round by index from an external key store, and returns the ciphertext through a valid/ready handshake. It sits between the host-side block interface and the round datapath/round-key RAM.

---
 rtl/aes_round_sched_if.sv | 30 +++
 rtl/aes_round_sched.sv | 180 ++++++++++++++++++
 tb/tb_aes_round_sched.sv | 327 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_round_sched_if.sv
// aes_round_sched_if
//   Host-side block handshake for the iterative AES-128 sequencer.
//   Plaintext enters on the in_* channel and ciphertext leaves on the out_*
//   channel. Both channels use valid/ready.
//   Ports (signals):
//     in_valid  : plaintext offer              (host -> sequencer)
//     in_ready  : sequencer can take a block   (sequencer -> host)
//     pt_in     : 128-bit plaintext            (host -> sequencer)
//     out_valid : ciphertext available         (sequencer -> host)
//     out_ready : host accepts ciphertext      (host -> sequencer)
//     ct_out    : 128-bit ciphertext           (sequencer -> host)
//   Modports: master = host side, slave = sequencer side.
interface aes_round_sched_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] pt_in;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] ct_out;

  modport master (
    output in_valid, pt_in, out_ready,
    input  in_ready, out_valid, ct_out
  );

  modport slave (
    input  in_valid, pt_in, out_ready,
    output in_ready, out_valid, ct_out
  );
endinterface

// File: rtl/aes_round_sched.sv
// aes_round_sched
//   Iterative AES-128 encryption sequencer. It accepts one plaintext block,
//   applies the initial AddRoundKey, and then runs an external round datapath
//   NR times. Each round takes RND_LAT cycles. One round key is fetched per
//   round by index from an external key store. The ciphertext is returned
//   over a valid/ready handshake.
//   Parameters:
//     NR      : number of cipher rounds (1..14)
//     RND_LAT : round datapath latency in cycles (1..15)
//   Ports:
//     clk, rst        : clock; asynchronous active-high reset
//     host            : block handshake (aes_round_sched_if.slave)
//     round_data_out  : state register to the round datapath
//     round_result_in : round datapath output
//     round_key_idx   : round-key index to the key store
//     round_key_in    : round key read combinationally from the key store
//     round_key_out   : round key forwarded to the datapath
//     last_round      : high throughout the final round (skip MixColumns)
//     round_start     : one-cycle pulse at the start of each round
//     busy            : high while the block is being processed
module aes_round_sched #(
  parameter int NR      = 10,
  parameter int RND_LAT = 2
) (
  input  logic                clk,
  input  logic                rst,
  aes_round_sched_if.slave    host,
  output logic [127:0]        round_data_out,
  input  logic [127:0]        round_result_in,
  output logic [3:0]          round_key_idx,
  input  logic [127:0]        round_key_in,
  output logic [127:0]        round_key_out,
  output logic                last_round,
  output logic                round_start,
  output logic                busy
);

  // The latency counter needs at least one bit, even when RND_LAT is 1.
  localparam int             LCW     = (RND_LAT > 1) ? $clog2(RND_LAT) : 1;
  localparam logic [LCW-1:0] LC_LAST = LCW'(RND_LAT - 1);
  localparam logic [3:0]     NR_IDX  = 4'(NR);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARK   = 2'd1,
    S_ROUND = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           state_r;
  state_t           next_state_s;
  logic [127:0]     st_r;
  logic [3:0]       rnd_r;
  logic [LCW-1:0]   lc_r;
  logic             lc_last_s;

  // The round result is valid in the last cycle of the round.
  assign lc_last_s = (lc_r == LC_LAST);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (host.in_valid) begin
          next_state_s = S_ARK;
        end else begin
          next_state_s = S_IDLE;
        end
      end
      S_ARK: begin
        next_state_s = S_ROUND;
      end
      S_ROUND: begin
        if (lc_last_s && (rnd_r == NR_IDX)) begin
          next_state_s = S_DONE;
        end else begin
          next_state_s = S_ROUND;
        end
      end
      S_DONE: begin
        if (host.out_ready) begin
          next_state_s = S_IDLE;
        end else begin
          next_state_s = S_DONE;
        end
      end
      default: begin
        next_state_s = S_IDLE;
      end
    endcase
  end

  // State, round counter and latency counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_r  <= 128'd0;
      rnd_r <= 4'd0;
      lc_r  <= '0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (host.in_valid) begin
            st_r  <= host.pt_in;
            rnd_r <= 4'd0;
          end
        end
        S_ARK: begin
          st_r  <= st_r ^ round_key_in;
          rnd_r <= 4'd1;
          lc_r  <= '0;
        end
        S_ROUND: begin
          if (!lc_last_s) begin
            lc_r <= lc_r + LCW'(1);
          end else begin
            st_r <= round_result_in;
            lc_r <= '0;
            // The counter stays at NR in DONE, which is harmless because
            // the round index is forced to zero outside ARK/ROUND.
            if (rnd_r != NR_IDX) begin
              rnd_r <= rnd_r + 4'd1;
            end
          end
        end
        default: begin
          // DONE holds the ciphertext until the next accept.
        end
      endcase
    end
  end

  // Handshake and round-control outputs, decoded from the registered state.
  always_comb begin
    host.in_ready  = 1'b0;
    host.out_valid = 1'b0;
    busy           = 1'b0;
    round_key_idx  = 4'd0;
    last_round     = 1'b0;
    round_start    = 1'b0;
    case (state_r)
      S_IDLE: begin
        host.in_ready = 1'b1;
      end
      S_ARK: begin
        busy          = 1'b1;
        round_key_idx = 4'd0;
      end
      S_ROUND: begin
        busy          = 1'b1;
        round_key_idx = rnd_r;
        last_round    = (rnd_r == NR_IDX);
        round_start   = (lc_r == '0);
      end
      S_DONE: begin
        host.out_valid = 1'b1;
      end
      default: begin
        host.in_ready = 1'b0;
      end
    endcase
  end

  // The state register feeds the datapath and the host directly. st_r only
  // changes in the last cycle of a round, so the datapath input is stable
  // for the whole round.
  assign round_data_out = st_r;
  assign host.ct_out    = st_r;
  assign round_key_out  = round_key_in;

endmodule

// File: tb/tb_aes_round_sched.sv
module tb_aes_round_sched;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- AES reference helpers ----------------
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, r;
    a = a_in; b = b_in; r = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) r = r ^ a;
      a = xt(a);
      b = b >> 1;
    end
    return r;
  endfunction

  // S-box: multiplicative inverse (x^254) followed by the affine transform.
  function automatic logic [7:0] sb(input logic [7:0] x);
    logic [7:0] p, r;
    p = x; r = 8'h01;
    for (int i = 0; i < 8; i++) begin
      if (i != 0) r = gmul(r, p);
      p = gmul(p, p);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] k, input logic last);
    logic [7:0] b [16];
    logic [7:0] t [16];
    logic [7:0] a0, a1, a2, a3;
    logic [127:0] o;
    for (int i = 0; i < 16; i++) b[i] = sb(s[127-8*i -: 8]);
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        t[r+4*c] = b[r+4*((c+r)%4)];
    if (!last) begin
      for (int c = 0; c < 4; c++) begin
        a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
        t[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
        t[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
        t[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
        t[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
      end
    end
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = t[i];
    return o ^ k;
  endfunction

  function automatic logic [127:0] ref_enc(input logic [127:0] pt, input logic [127:0] ks [0:15], input int nr);
    logic [127:0] s;
    s = pt ^ ks[0];
    for (int k = 1; k <= nr; k++) s = aes_round(s, ks[k], k == nr);
    return s;
  endfunction

  // ---------------- DUT A: NR=10, RND_LAT=2 ----------------
  aes_round_sched_if ifa();
  logic [127:0] rdo_a, rri_a, rki_a, rko_a;
  logic [3:0]   idx_a;
  logic         last_a, start_a, busy_a;
  logic [127:0] ksa [0:15];

  assign rki_a = ksa[idx_a];
  // Two-cycle round datapath model: one register stage after the input.
  always @(posedge clk) rri_a <= aes_round(rdo_a, rko_a, last_a);

  aes_round_sched #(.NR(10), .RND_LAT(2)) u_dut_a (
    .clk(clk), .rst(rst), .host(ifa),
    .round_data_out(rdo_a), .round_result_in(rri_a),
    .round_key_idx(idx_a), .round_key_in(rki_a), .round_key_out(rko_a),
    .last_round(last_a), .round_start(start_a), .busy(busy_a)
  );

  // ---------------- DUT B: NR=14, RND_LAT=1 ----------------
  aes_round_sched_if ifb();
  logic [127:0] rdo_b, rri_b, rki_b, rko_b;
  logic [3:0]   idx_b;
  logic         last_b, start_b, busy_b;
  logic [127:0] ksb [0:15];

  assign rki_b = ksb[idx_b];
  assign rri_b = aes_round(rdo_b, rko_b, last_b);

  aes_round_sched #(.NR(14), .RND_LAT(1)) u_dut_b (
    .clk(clk), .rst(rst), .host(ifb),
    .round_data_out(rdo_b), .round_result_in(rri_b),
    .round_key_idx(idx_b), .round_key_in(rki_b), .round_key_out(rko_b),
    .last_round(last_b), .round_start(start_b), .busy(busy_b)
  );

  // ---------------- checking and scoreboard ----------------
  logic [127:0] exp_q [$];
  int           acc_q [$];
  logic [127:0] expb_q [$];

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] stat_a();
    return {119'd0, ifa.in_ready, ifa.out_valid, busy_a, last_a, start_a, idx_a};
  endfunction

  task automatic expand_key(input logic [127:0] key);
    logic [31:0] w [0:43];
    logic [31:0] tmp;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {sb(tmp[23:16]), sb(tmp[15:8]), sb(tmp[7:0]), sb(tmp[31:24])} ^ {rc, 24'h000000};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int k = 0; k < 16; k++)
      ksa[k] = (k <= 10) ? {w[4*k], w[4*k+1], w[4*k+2], w[4*k+3]} : 128'd0;
  endtask

  // Output-side monitor on DUT A: latency on the rising out_valid, ciphertext on handshake.
  logic ov_prev = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      ov_prev <= 1'b0;
    end else begin
      if (ifa.out_valid && !ov_prev) begin
        if (acc_q.size() == 0) check("spurious_out_valid", 128'd1, 128'd0);
        else check("latency", 128'(cyc - acc_q[0]), 128'd22);
      end
      if (ifa.out_valid && ifa.out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_ct", 128'd1, 128'd0);
        end else begin
          check("ct", ifa.ct_out, exp_q.pop_front());
          void'(acc_q.pop_front());
        end
      end
      ov_prev <= ifa.out_valid;
    end
  end

  // Offer a block; on accept push the expected ciphertext and the accept cycle.
  // Called and returns at #1 after a rising edge.
  task automatic send(input logic [127:0] pt, input logic [127:0] exp, input bit keep, output int t);
    int n;
    n = 0; t = -1;
    ifa.in_valid = 1'b1;
    ifa.pt_in    = pt;
    while (!ifa.in_ready && n < 100) begin
      @(posedge clk); #1; n++;
    end
    if (!ifa.in_ready) begin
      check("accept_timeout", 128'd0, 128'd1);
      ifa.in_valid = 1'b0;
      return;
    end
    exp_q.push_back(exp);
    acc_q.push_back(cyc);
    t = cyc;
    @(posedge clk); #1;
    if (!keep) ifa.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk); #1; n++;
    end
    if (exp_q.size() != 0) begin
      check("drain_timeout", 128'(exp_q.size()), 128'd0);
      exp_q.delete();
      acc_q.delete();
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int t, n, starts;
    int tt [4];
    bit ov_seen;
    logic [127:0] p1, p2, e1, pb, pt;
    logic [31:0] w;

    ifa.in_valid = 1'b0; ifa.pt_in = 128'd0; ifa.out_ready = 1'b1;
    ifb.in_valid = 1'b0; ifb.pt_in = 128'd0; ifb.out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      ksa[i] = 128'd0;
      w = 32'h9e3779b9 * 32'(i + 1);
      ksb[i] = {w, ~w, w ^ 32'h5a5a5a5a, w[15:0], w[31:16]};
    end

    // Reset state, during and after reset.
    repeat (2) @(posedge clk);
    #1;
    check("rst_status", stat_a(), 128'h100);
    check("rst_ct", ifa.ct_out, 128'd0);
    check("rst_rdo", rdo_a, 128'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("idle_status", stat_a(), 128'h100);

    // FIPS-197 C.1.
    expand_key(128'h000102030405060708090a0b0c0d0e0f);
    send(128'h00112233445566778899aabbccddeeff, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, 1'b0, t);
    drain();

    // FIPS-197 App. B with round-key index / last_round / round_start sequence.
    expand_key(128'h2b7e151628aed2a6abf7158809cf4f3c);
    send(128'h3243f6a8885a308d313198a2e0370734, 128'h3925841d02dc09fbdc118597196a0b32, 1'b0, t);
    for (int j = 0; j < 21; j++) begin
      logic [5:0] e;
      int k;
      if (j == 0) begin
        e = 6'h00;
      end else begin
        k = (j - 1) / 2 + 1;
        e = {((j - 1) % 2 == 0), (k == 10), 4'(k)};
      end
      check($sformatf("seq%0d", j), {122'd0, start_a, last_a, idx_a}, {122'd0, e});
      @(posedge clk); #1;
    end
    drain();

    // Backpressure with in_valid held high throughout.
    ifa.out_ready = 1'b0;
    p1 = 128'hdeadbeef_01234567_89abcdef_cafef00d;
    p2 = 128'h0f1e2d3c_4b5a6978_8796a5b4_c3d2e1f0;
    e1 = ref_enc(p1, ksa, 10);
    send(p1, e1, 1'b1, t);
    ifa.pt_in = p2;
    n = 0;
    while (!ifa.out_valid && n < 40) begin
      @(posedge clk); #1; n++;
    end
    check("bp_out_valid", 128'(ifa.out_valid), 128'd1);
    for (int j = 0; j < 50; j++) begin
      check("bp_in_ready", 128'(ifa.in_ready), 128'd0);
      check("bp_ct_stable", ifa.ct_out, e1);
      @(posedge clk); #1;
    end
    ifa.out_ready = 1'b1;
    @(posedge clk); #1;
    ifa.out_ready = 1'b0;
    check("bp_idle_ready", 128'(ifa.in_ready), 128'd1);
    exp_q.push_back(ref_enc(p2, ksa, 10));
    acc_q.push_back(cyc);
    @(posedge clk); #1;
    ifa.in_valid = 1'b0;
    check("bp_second_accept", 128'(busy_a), 128'd1);
    ifa.out_ready = 1'b1;
    drain();

    // Reset during round 5.
    pt = 128'h11112222_33334444_55556666_77778888;
    send(pt, ref_enc(pt, ksa, 10), 1'b0, t);
    repeat (9) begin @(posedge clk); #1; end
    check("pre_reset_idx", 128'(idx_a), 128'd5);
    rst = 1'b1;
    #1;
    check("mid_rst_status", stat_a(), 128'h100);
    check("mid_rst_ct", ifa.ct_out, 128'd0);
    check("mid_rst_rdo", rdo_a, 128'd0);
    exp_q.delete();
    acc_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    ov_seen = 1'b0;
    repeat (30) begin
      @(posedge clk); #1;
      if (ifa.out_valid) ov_seen = 1'b1;
    end
    check("no_out_after_reset", 128'(ov_seen), 128'd0);
    pt = 128'h99990000_aaaabbbb_ccccdddd_eeeeffff;
    send(pt, ref_enc(pt, ksa, 10), 1'b0, t);
    drain();

    // Back-to-back, consumer always ready.
    for (int i = 0; i < 4; i++) begin
      pt = {$urandom(), $urandom(), $urandom(), $urandom()};
      send(pt, ref_enc(pt, ksa, 10), 1'b0, tt[i]);
    end
    drain();
    for (int i = 1; i < 4; i++) check($sformatf("b2b_gap%0d", i), 128'(tt[i] - tt[i-1]), 128'd23);

    // Parameter sweep instance: NR=14, RND_LAT=1.
    pb = 128'h00112233_44556677_8899aabb_ccddeeff;
    check("b_in_ready", 128'(ifb.in_ready), 128'd1);
    ifb.in_valid = 1'b1;
    ifb.pt_in    = pb;
    expb_q.push_back(ref_enc(pb, ksb, 14));
    @(posedge clk); #1;
    ifb.in_valid = 1'b0;
    n = 1; starts = 0;
    while (!ifb.out_valid && n < 60) begin
      if (start_b) starts++;
      @(posedge clk); #1; n++;
    end
    check("b_latency", 128'(n), 128'd16);
    check("b_round_starts", 128'(starts), 128'd14);
    if (ifb.out_valid) check("b_ct", ifb.ct_out, expb_q.pop_front());
    else check("b_out_timeout", 128'd0, 128'd1);
    @(posedge clk); #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
